// File: rtl/timer_pkg.sv
// Shared constants and helpers for the delay timer bank: clock divisors and
// the per-channel state encoding.
package timer_pkg;

    localparam int DEFAULT_CLK_FREQ = 12_000_000;

    // Clocks per microsecond (unit_ms = 0) or per millisecond (unit_ms = 1), never below 1.
    function automatic int div_for(input int clk_freq, input bit unit_ms);
        int d;
        d = unit_ms ? (clk_freq / 1_000) : (clk_freq / 1_000_000);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic int presc_width(input int ms_div);
        return (ms_div > 1) ? $clog2(ms_div) : 1;
    endfunction

    localparam int US_DIV = div_for(DEFAULT_CLK_FREQ, 1'b0);
    localparam int MS_DIV = div_for(DEFAULT_CLK_FREQ, 1'b1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/delay_timer_bank_if.sv
// Control/status bundle of the delay timer bank: per-channel strobes, load
// values and the busy/done status returned by the bank.
interface delay_timer_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       cancel;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       unit_ms;
    logic [N_CH-1:0]       periodic;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       done;

    modport master (
        output start, cancel, count, unit_ms, periodic,
        input  busy, done
    );

    modport slave (
        input  start, cancel, count, unit_ms, periodic,
        output busy, done
    );
endinterface

// File: rtl/delay_timer_channel.sv
// One timer channel: per-channel prescaler and unit counter, latched load
// values, IDLE/RUN FSM and registered busy/done.
module delay_timer_channel
    import timer_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] count,
    input  logic             unit_ms,
    input  logic             periodic,
    output logic             busy,
    output logic             done
);

    localparam int CH_US_DIV = div_for(CLK_FREQ, 1'b0);
    localparam int CH_MS_DIV = div_for(CLK_FREQ, 1'b1);
    localparam int PW        = presc_width(CH_MS_DIV);

    localparam logic [PW-1:0] US_LAST   = PW'(CH_US_DIV - 1);
    localparam logic [PW-1:0] MS_LAST   = PW'(CH_MS_DIV - 1);
    localparam logic          US_IS_ONE = (CH_US_DIV == 1);
    localparam logic          MS_IS_ONE = (CH_MS_DIV == 1);

    ch_state_e        state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] units_q, units_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             unit_ms_q, unit_ms_d;
    logic             periodic_q, periodic_d;
    logic             fire_q, fire_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [PW-1:0]    start_last;
    logic [PW-1:0]    run_last;
    logic             t_one;
    logic             expire;

    // A period of one clock never enters RUN; fire_q carries its single done pulse.
    always_comb begin
        start_last = unit_ms ? MS_LAST : US_LAST;
        run_last   = unit_ms_q ? MS_LAST : US_LAST;
        t_one      = (count == '0) || ((count == CNT_W'(1)) && (unit_ms ? MS_IS_ONE : US_IS_ONE));
        expire     = fire_q || ((state_q == ST_RUN) && (presc_q == '0) && (units_q == '0));
    end

    always_comb begin
        // NOTE: every signal gets its default first so no branch leaves one unassigned (no latch).
        state_d    = state_q;
        presc_d    = presc_q;
        units_d    = units_q;
        count_d    = count_q;
        unit_ms_d  = unit_ms_q;
        periodic_d = periodic_q;
        fire_d     = 1'b0;
        done_d     = 1'b0;

        if (cancel) begin
            state_d = ST_IDLE;
        end else if (start) begin
            count_d    = count;
            unit_ms_d  = unit_ms;
            periodic_d = periodic && !t_one;
            if (t_one) begin
                state_d = ST_IDLE;
                fire_d  = 1'b1;
                presc_d = '0;
                units_d = '0;
            end else begin
                state_d = ST_RUN;
                presc_d = start_last;
                units_d = count - CNT_W'(1);
            end
        end else if (expire) begin
            done_d = 1'b1;
            if ((state_q == ST_RUN) && periodic_q) begin
                presc_d = run_last;
                units_d = count_q - CNT_W'(1);
            end else begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_RUN) begin
            if (presc_q != '0) begin
                presc_d = presc_q - PW'(1);
            end else begin
                presc_d = run_last;
                units_d = units_q - CNT_W'(1);
            end
        end

        // busy covers the cycles strictly after the start edge until expiry.
        busy_d = (state_d == ST_RUN) && !start;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            units_q    <= '0;
            count_q    <= '0;
            unit_ms_q  <= 1'b0;
            periodic_q <= 1'b0;
            fire_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            units_q    <= units_d;
            count_q    <= count_d;
            unit_ms_q  <= unit_ms_d;
            periodic_q <= periodic_d;
            fire_q     <= fire_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of independent delay/interval timers; each channel runs its own
// prescaler so channels never share phase.
module delay_timer_bank
    import timer_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    delay_timer_bank_if.slave  bus
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        delay_timer_channel #(
            .CLK_FREQ (CLK_FREQ),
            .CNT_W    (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start    (bus.start[i]),
            .cancel   (bus.cancel[i]),
            .count    (bus.count[i*CNT_W +: CNT_W]),
            .unit_ms  (bus.unit_ms[i]),
            .periodic (bus.periodic[i]),
            .busy     (bus.busy[i]),
            .done     (bus.done[i])
        );
    end

endmodule

// File: tb/tb_delay_timer_bank.sv
// Self-checking bench for delay_timer_bank: vector table, hand-written
// corner sequences and randomized traffic against a cycle-schedule model.
module tb_delay_timer_bank;

    localparam int CLK_FREQ = 120_000;
    localparam int N_CH     = 4;
    localparam int CNT_W    = 16;
    localparam int LOG_LEN  = 1024;
    localparam longint US_DIV_M = (CLK_FREQ / 1_000_000 < 1) ? 1 : CLK_FREQ / 1_000_000;
    localparam longint MS_DIV_M = (CLK_FREQ / 1_000 < 1) ? 1 : CLK_FREQ / 1_000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    delay_timer_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    delay_timer_bank #(
        .CLK_FREQ (CLK_FREQ),
        .N_CH     (N_CH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    longint base    = 0;

    // Model: each running channel keeps the absolute edge of its next expiry.
    bit              m_run  [N_CH];
    bit              m_per  [N_CH];
    longint          m_next [N_CH];
    longint          m_t    [N_CH];
    logic [N_CH-1:0] m_busy;
    logic [N_CH-1:0] m_done;

    bit busy_log [N_CH][LOG_LEN];
    bit done_log [N_CH][LOG_LEN];
    int first_done [N_CH];
    int done_n [N_CH];
    int busy_n [N_CH];

    typedef struct {
        int ch;
        int cnt;
        bit ms;
        bit per;
        int win;
        int exp_first;
        int exp_busy;
        int exp_dones;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        m_done = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            bit started;
            started = 1'b0;
            if (rst) begin
                m_run[ch] = 1'b0;
            end else if (bus.cancel[ch]) begin
                m_run[ch] = 1'b0;
            end else if (bus.start[ch]) begin
                longint t;
                t = longint'(bus.count[ch*CNT_W +: CNT_W]) * (bus.unit_ms[ch] ? MS_DIV_M : US_DIV_M);
                if (t < 1) t = 1;
                m_run[ch]  = 1'b1;
                m_t[ch]    = t;
                m_next[ch] = cyc + t;
                m_per[ch]  = bus.periodic[ch] && (t > 1);
                started    = 1'b1;
            end else if (m_run[ch] && (m_next[ch] == cyc)) begin
                m_done[ch] = 1'b1;
                if (m_per[ch]) m_next[ch] = m_next[ch] + m_t[ch];
                else           m_run[ch]  = 1'b0;
            end
            m_busy[ch] = m_run[ch] && !started;
        end
    endfunction

    task automatic tick();
        longint rel;
        @(posedge clk);
        model_edge();
        #1;
        check("busy_vs_model", bus.busy, m_busy);
        check("done_vs_model", bus.done, m_done);
        rel = cyc - base;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (rel >= 0 && rel < LOG_LEN) begin
                busy_log[ch][rel] = bus.busy[ch];
                done_log[ch][rel] = bus.done[ch];
            end
            if (bus.done[ch] === 1'b1) begin
                if (first_done[ch] < 0) first_done[ch] = int'(rel);
                done_n[ch]++;
            end
            if (bus.busy[ch] === 1'b1) busy_n[ch]++;
        end
        cyc++;
        rst        = 1'b0;
        bus.start  = '0;
        bus.cancel = '0;
    endtask

    task automatic clear_log();
        base = cyc;
        for (int ch = 0; ch < N_CH; ch++) begin
            first_done[ch] = -1;
            done_n[ch]     = 0;
            busy_n[ch]     = 0;
            for (int i = 0; i < LOG_LEN; i++) begin
                busy_log[ch][i] = 1'b0;
                done_log[ch][i] = 1'b0;
            end
        end
    endtask

    task automatic advance_to(input longint e);
        while (cyc - base < e) tick();
    endtask

    task automatic arm(input int ch, input int cnt, input bit ms, input bit per);
        bus.start[ch]                 = 1'b1;
        bus.count[ch*CNT_W +: CNT_W]  = CNT_W'(cnt);
        bus.unit_ms[ch]               = ms;
        bus.periodic[ch]              = per;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("reset_busy", bus.busy, '0);
        check("reset_done", bus.done, '0);
    endtask

    function automatic int busy_ones(input int ch, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) if (busy_log[ch][i]) n++;
        return n;
    endfunction

    function automatic int done_ones(input int ch, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) if (done_log[ch][i]) n++;
        return n;
    endfunction

    initial begin
        bus.start    = '0;
        bus.cancel   = '0;
        bus.count    = '0;
        bus.unit_ms  = '0;
        bus.periodic = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_run[ch]  = 1'b0;
            m_per[ch]  = 1'b0;
            m_next[ch] = 0;
            m_t[ch]    = 1;
        end
        clear_log();
        do_reset();

        // ch, count, ms, periodic, window, first done, busy cycles, dones in window
        vecs[0] = '{0, 0, 1'b0, 1'b0, 20,  1,   0,   1};
        vecs[1] = '{1, 0, 1'b1, 1'b1, 20,  1,   0,   1};
        vecs[2] = '{2, 1, 1'b0, 1'b1, 20,  1,   0,   1};
        vecs[3] = '{3, 1, 1'b1, 1'b0, 150, 120, 119, 1};
        vecs[4] = '{0, 2, 1'b0, 1'b0, 20,  2,   1,   1};
        vecs[5] = '{2, 6, 1'b0, 1'b1, 30,  6,   30,  5};
        vecs[6] = '{3, 2, 1'b1, 1'b1, 250, 240, 250, 1};
        vecs[7] = '{1, 3, 1'b1, 1'b0, 400, 360, 359, 1};

        foreach (vecs[i]) begin
            do_reset();
            clear_log();
            arm(vecs[i].ch, vecs[i].cnt, vecs[i].ms, vecs[i].per);
            tick();
            advance_to(vecs[i].win + 1);
            check($sformatf("vec%0d_first_done", i), first_done[vecs[i].ch], vecs[i].exp_first);
            check($sformatf("vec%0d_busy_cycles", i), busy_n[vecs[i].ch], vecs[i].exp_busy);
            check($sformatf("vec%0d_done_count", i), done_n[vecs[i].ch], vecs[i].exp_dones);
        end

        // One-shot in milliseconds started at edge 10.
        do_reset();
        clear_log();
        advance_to(10);
        arm(0, 3, 1'b1, 1'b0);
        tick();
        advance_to(400);
        check("ms_first_done", first_done[0], 370);
        check("ms_done_count", done_n[0], 1);
        check("ms_busy_window", busy_ones(0, 11, 369), 359);
        check("ms_busy_before", busy_ones(0, 0, 10), 0);
        check("ms_busy_after", busy_ones(0, 370, 399), 0);

        // Periodic microseconds, cancelled at edge 17.
        do_reset();
        clear_log();
        arm(1, 5, 1'b0, 1'b1);
        tick();
        advance_to(17);
        bus.cancel[1] = 1'b1;
        tick();
        advance_to(40);
        check("per_done5", done_log[1][5], 1);
        check("per_done10", done_log[1][10], 1);
        check("per_done15", done_log[1][15], 1);
        check("per_no_done20", done_log[1][20], 0);
        check("per_done_count", done_n[1], 3);
        check("per_busy_run", busy_ones(1, 1, 16), 16);
        check("per_busy_after_cancel", busy_ones(1, 18, 39), 0);

        // Retrigger at the edge the first run would expire.
        do_reset();
        clear_log();
        arm(2, 10, 1'b0, 1'b0);
        tick();
        advance_to(10);
        arm(2, 4, 1'b0, 1'b0);
        tick();
        advance_to(30);
        check("retrig_no_done10", done_log[2][10], 0);
        check("retrig_first_done", first_done[2], 14);
        check("retrig_done_count", done_n[2], 1);
        check("retrig_busy_old", busy_ones(2, 1, 9), 9);
        check("retrig_busy_new", busy_ones(2, 11, 13), 3);
        check("retrig_busy_after", busy_ones(2, 14, 29), 0);

        // cancel together with start, and cancel of an idle channel.
        do_reset();
        clear_log();
        arm(3, 5, 1'b0, 1'b0);
        bus.cancel[3] = 1'b1;
        bus.cancel[0] = 1'b1;
        tick();
        advance_to(20);
        check("cs_busy", busy_n[3], 0);
        check("cs_done", done_n[3], 0);
        check("idle_cancel_done", done_n[0], 0);

        // count = 0 started at edge 5, periodic ignored.
        do_reset();
        clear_log();
        advance_to(5);
        arm(0, 0, 1'b1, 1'b1);
        tick();
        advance_to(20);
        check("zero_first_done", first_done[0], 6);
        check("zero_done_count", done_n[0], 1);
        check("zero_busy", busy_n[0], 0);

        // Largest count in microseconds.
        do_reset();
        clear_log();
        arm(1, 16'hFFFF, 1'b0, 1'b0);
        tick();
        advance_to(65540);
        check("max_first_done", first_done[1], 65535);
        check("max_done_count", done_n[1], 1);
        check("max_busy_cycles", busy_n[1], 65534);

        // Reset while all channels run.
        do_reset();
        clear_log();
        arm(0, 100, 1'b0, 1'b0);
        arm(1, 3, 1'b1, 1'b1);
        arm(2, 60, 1'b0, 1'b1);
        arm(3, 1, 1'b1, 1'b0);
        tick();
        advance_to(50);
        rst = 1'b1;
        tick();
        advance_to(400);
        for (int ch = 0; ch < N_CH; ch++) begin
            check($sformatf("rstmid_busy_before_ch%0d", ch), busy_ones(ch, 1, 49), 49);
            check($sformatf("rstmid_busy_after_ch%0d", ch), busy_ones(ch, 51, 399), 0);
            check($sformatf("rstmid_done_ch%0d", ch), done_ones(ch, 0, 399), 0);
        end

        // Two channels expiring on the same cycle.
        do_reset();
        clear_log();
        arm(0, 200, 1'b0, 1'b0);
        arm(1, 7, 1'b0, 1'b1);
        tick();
        advance_to(80);
        arm(3, 1, 1'b1, 1'b0);
        tick();
        advance_to(210);
        check("ind_ch0_done200", done_log[0][200], 1);
        check("ind_ch3_done200", done_log[3][200], 1);
        check("ind_ch0_count", done_n[0], 1);
        check("ind_ch3_count", done_n[3], 1);
        check("ind_ch1_done196", done_log[1][196], 1);
        check("ind_ch1_done203", done_log[1][203], 1);
        check("ind_ch1_no200", done_log[1][200], 0);
        check("ind_ch1_count", done_n[1], 29);
        check("ind_ch2_done", done_n[2], 0);
        check("ind_ch2_busy", busy_n[2], 0);

        // Randomized traffic, checked every cycle against the model.
        do_reset();
        clear_log();
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 1) == 1)
                        arm(ch, int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
                    else
                        arm(ch, int'($urandom_range(0, 40)), 1'b0, 1'($urandom_range(0, 1)));
                end
                if ($urandom_range(0, 39) == 0) bus.cancel[ch] = 1'b1;
            end
            if ($urandom_range(0, 799) == 0) rst = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_timer_bank.md
# delay_timer_bank

Parametrised multi-channel delay/interval timer, replacing the ad-hoc per-state delay counters in the display init and refresh sequencers. Each channel is started with a count in microsecond or millisecond units, derived from `CLK_FREQ`. On expiry it emits a one-cycle `done` pulse, either once or periodically. Sits beside the panel command sequencer in `top`. `CLK_FREQ` is scaled down in simulation to shorten waveforms.

## Interface
- `CLK_FREQ`, 12_000_000: clock frequency in Hz.
- `N_CH`, 4: number of independent channels.
- `CNT_W`, 16: width of each channel's count.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  N_CH: per-channel start/retrigger strobe.
- `cancel`  in  N_CH: per-channel abort strobe.
- `count`  in  N_CH*CNT_W: channel i count at `[i*CNT_W +: CNT_W]`, sampled with `start[i]`.
- `unit_ms`  in  N_CH: 0 = microseconds, 1 = milliseconds; sampled with `start[i]`.
- `periodic`  in  N_CH: 1 = auto-reload after expiry; sampled with `start[i]`.
- `busy`  out  N_CH: channel running.
- `done`  out  N_CH: one-cycle expiry pulse.

## Operation
- Divisors:
  - `US_DIV = max(1, CLK_FREQ/1_000_000)`
  - `MS_DIV = max(1, CLK_FREQ/1_000)`
  - Integer division, truncating.
- Each channel has its own prescaler, so there is no phase error against other channels.
- Period `T = max(1, count*DIV)`, in clocks. `DIV` is the divisor selected by `unit_ms`.
- Per-channel states are IDLE and RUN.
  - IDLE → RUN on `start` (when `T > 1`).
  - RUN → IDLE on expiry (one-shot) or on `cancel`.
  - RUN → RUN on expiry when periodic, with the latched `count`/unit reloaded.
- Internal counters:
  - prescaler width is `$clog2(MS_DIV)`, minimum 1.
  - remaining-units counter width is `CNT_W`.
  - There is no multiplication in hardware.
- Priority per channel per cycle is `rst` > `cancel` > `start` > expiry.
  - `cancel` with `start` in the same cycle: channel goes IDLE, no `done`.
  - `start` while RUN: retrigger. Reload from the new inputs, no `done` for the aborted run, even if it would have expired on that edge.
  - `cancel` while IDLE: no effect.
- `count = 0`: `done` pulses once, one cycle after `start`. `busy` never rises. `periodic` is ignored (one-shot).
- Periodic mode with `T = 1`: treated as one-shot. This avoids a permanently high `done`.
- Channels are fully independent; any number may expire in the same cycle.

## Timing
- Reset: `busy` = 0, `done` = 0, all channel state IDLE, counters cleared. This applies on the first edge with `rst` high, including mid-run. No `done` is produced for runs killed by reset.
- `start` sampled at edge k:
  - `busy` high in cycles k+1 … k+T-1.
  - `done` high in cycle k+T only, with `busy` low that cycle (one-shot).
- Periodic:
  - `done` high in cycles k+T, k+2T, …
  - `busy` stays high continuously from k+1 until `cancel`/`rst`, including the `done` cycles.
- `cancel` sampled at edge c: `busy` low from cycle c+1, and no `done` at or after c+1.
- All outputs are registered. There is no combinational input→output path.

## Structure
- Package `timer_pkg` holds:
  - function `div_for(clk_freq, unit_ms)` returning the clamped divisor;
  - constants `US_DIV`/`MS_DIV` computed from it;
  - localparam state encoding `ST_IDLE`/`ST_RUN`.
- Sub-module `delay_timer_channel` holds one channel: prescaler, unit counter, latched `count`/`unit_ms`/`periodic`, FSM, `busy`/`done` registers.
- `delay_timer_bank` is a generate loop of `N_CH` channel instances plus port slicing.

## Test plan
All scenarios use `CLK_FREQ=120_000`, so `US_DIV=1` and `MS_DIV=120`; `N_CH=4`, `CNT_W=16`.
- One-shot ms: ch0 `start` at edge 10, `count=3`, `unit_ms=1` → `busy[0]` high cycles 11–369, `done[0]` high only in cycle 370.
- Periodic us plus cancel: ch1 `count=5`, `periodic=1`, start at edge 0 → `done[1]` at cycles 5, 10, 15. `cancel` at edge 17 → `busy[1]` low from 18, no `done` at 20.
- Retrigger: ch2 `count=10` us, start at edge 0, then start at edge 10 with `count=4` → no `done` at 10, `done[2]` at 14.
- Boundaries:
  - `count=0` start → `done` at k+1, `busy` never high.
  - `count=1` us periodic → single `done` at k+1.
  - `cancel`+`start` in the same cycle → stays IDLE.
  - `count=16'hFFFF` us → `done` at k+65535.
- Reset mid-run: all four channels running, `rst` pulsed at edge 50 → all `busy`/`done` are 0 from cycle 51, and no later `done` appears without a new `start`.
- Independence: ch0 and ch3 both set for expiry at cycle 200 → both `done` bits high in cycle 200; ch1/ch2 unaffected.
